rmt_ingress_arb: RTL and testbench
==================================

Name: rmt_ingress_arb

Overview:
- Frame-atomic round-robin arbiter that merges PORT_COUNT AXI-Stream ingress streams into the single stream feeding the match-action classifier.
- Grants one source at a time and holds the grant until that source's tlast beat.
- Tags every output beat with the source index on m_axis_tid.
- Output passes through a 2-entry skid buffer, so s_axis_tready never depends combinationally on m_axis_tready, and full throughput is kept across frame boundaries.

Parameters:
- DATA_WIDTH, 512, per-port tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, per-port tkeep width.
- USER_WIDTH, 1, per-port tuser width.
- PORT_COUNT, 4, number of ingress ports; legal range 2..16.
- ID_WIDTH, $clog2(PORT_COUNT), width of m_axis_tid and grant_port.

Ports:
- clk  in  1  single clock; all logic synchronous to rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  PORT_COUNT*DATA_WIDTH  packed; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  PORT_COUNT*KEEP_WIDTH  packed per port.
- s_axis_tvalid  in  PORT_COUNT  per-port valid.
- s_axis_tready  out  PORT_COUNT  per-port ready.
- s_axis_tlast  in  PORT_COUNT  per-port last.
- s_axis_tuser  in  PORT_COUNT*USER_WIDTH  packed per port.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  KEEP_WIDTH  merged keep.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged last.
- m_axis_tuser  out  USER_WIDTH  merged user.
- m_axis_tid  out  ID_WIDTH  source port of the beat.
- port_en  in  PORT_COUNT  per-port arbitration enable (configuration).
- busy  out  1  grant currently held (LOCKED state).
- grant_port  out  ID_WIDTH  currently or last granted port.

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; skid buffer emptied.
  - m_axis_tvalid=0, all m_axis data/keep/last/user/tid=0.
  - s_axis_tready=0, busy=0, grant_port=0.
  - Priority pointer set so port 0 has highest priority next.
- Reset deassertion is synchronised internally; first grant is possible on the 2nd rising edge after rst_n rises.
- States:
  - IDLE: no grant. Candidates = s_axis_tvalid & port_en. Winner = first candidate searching from pointer upward, mod PORT_COUNT. If a winner exists and the skid buffer has space, its first beat is accepted in the same cycle (combinational grant). Next state is LOCKED, or stays IDLE if that beat carries tlast.
  - LOCKED: only the granted port sees s_axis_tready = buffer-not-full. On an accepted beat with tlast, next state is IDLE.
- Pointer update: on the accepted tlast beat of port k, pointer <= (k+1) mod PORT_COUNT.
- No bubble between frames: if tlast is accepted in cycle N, the next frame's first beat (any port) is acceptable in cycle N+1.
- s_axis_tready is 0 on all non-granted ports at all times.
- Skid buffer ready is registered: s_axis_tready = !full, where full means 2 entries are held.
- Latency: a beat accepted at edge N appears on m_axis at edge N+1 when the buffer was empty.
- m_axis signals hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- port_en changes:
  - Sampled only at arbitration. Clearing port_en[k] mid-frame of k does not truncate the frame.
  - port_en=0 for all ports means no grants; IDLE is held.
- A granted port dropping tvalid mid-frame leaves the state LOCKED; the grant is not released before tlast.
- busy=1 exactly while in LOCKED. grant_port updates in the cycle the first beat is accepted and holds until the next grant.
- Reset mid-frame: the partial frame is discarded (no tlast emitted). This is documented and acceptable; the downstream classifier returns to idle on its own reset.
- Single-beat frames (tlast on first beat) never enter LOCKED; back-to-back single-beat frames from different ports sustain 1 beat/cycle.

Test Plan:
- Ports 0..3 each offer one 3-beat frame simultaneously, m_axis_tready=1 → output order tid 0,1,2,3; 12 contiguous valid beats; tlast on beats 3,6,9,12; no idle cycle between frames.
- Port 2 sends a 4-beat frame; port 0 raises tvalid at beat 2 → port 0 s_axis_tready stays 0 until port 2 tlast is accepted; port 0's frame follows with tid=0 on the next cycle.
- Continuous traffic on ports 1 and 3, m_axis_tready toggled 1,0,0,1 repeatedly → no beat lost or duplicated; data held stable while stalled; tid alternates 1,3,1,3 per frame.
- port_en=4'b1011 with all ports valid → port 2 never granted; port_en[0] cleared mid-frame of port 0 → that frame completes; port 0 is not granted again.
- Single-beat frames on all 4 ports, repeated 8 times → 32 output beats in 32 consecutive cycles, tid sequence 0,1,2,3 repeated.
- rst_n asserted at beat 2 of a 5-beat frame → m_axis_tvalid=0, s_axis_tready=0 immediately (async); after release, port 0 wins first arbitration.

Source files
------------

// File: rtl/rmt_ingress_arb_if.sv
// Signal bundle for rmt_ingress_arb: PORT_COUNT ingress AXI-Stream ports, merged egress stream, config and status.
interface rmt_ingress_arb_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int PORT_COUNT = 4,
  parameter int ID_WIDTH   = $clog2(PORT_COUNT)
);
  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [PORT_COUNT-1:0]            s_axis_tvalid;
  logic [PORT_COUNT-1:0]            s_axis_tready;
  logic [PORT_COUNT-1:0]            s_axis_tlast;
  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic [KEEP_WIDTH-1:0]            m_axis_tkeep;
  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic                             m_axis_tlast;
  logic [USER_WIDTH-1:0]            m_axis_tuser;
  logic [ID_WIDTH-1:0]              m_axis_tid;
  logic [PORT_COUNT-1:0]            port_en;
  logic                             busy;
  logic [ID_WIDTH-1:0]              grant_port;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  m_axis_tready, port_en,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
    output busy, grant_port
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output m_axis_tready, port_en,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
    input  busy, grant_port
  );
endinterface

// File: rtl/rmt_ingress_arb.sv
// Frame-atomic round-robin merge of PORT_COUNT AXI-Stream ports onto one tid-tagged stream.
// One cycle latency via a 2-entry skid buffer; s_axis_tready is buffer-not-full from registers only.
module rmt_ingress_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int PORT_COUNT = 4,
  parameter int ID_WIDTH   = $clog2(PORT_COUNT)
) (
  input logic              clk,
  input logic              rst_n,
  rmt_ingress_arb_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [ID_WIDTH-1:0]   tid;
  } beat_t;

  logic                  run;
  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   sel;
  logic                  found;
  logic                  sel_vld;
  logic                  buf_rdy;
  logic                  push;
  logic                  pop;
  logic [PORT_COUNT-1:0] cand;
  logic [PORT_COUNT-1:0] ready;
  logic [1:0]            cnt;
  beat_t                 in_beat;
  beat_t                 head;
  beat_t                 tail;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] k);
    return (k == ID_WIDTH'(PORT_COUNT - 1)) ? '0 : k + 1'b1;
  endfunction

  // Release of rst_n is retimed so arbitration starts one edge after the reset edge is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_comb begin
    cand   = bus.s_axis_tvalid & bus.port_en;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (!found && cand[ID_WIDTH'((int'(ptr) + i) % PORT_COUNT)]) begin
        found  = 1'b1;
        winner = ID_WIDTH'((int'(ptr) + i) % PORT_COUNT);
      end
    end
  end

  assign sel     = (state == ST_LOCKED) ? grant : winner;
  assign sel_vld = (state == ST_LOCKED) || found;
  assign buf_rdy = run && (cnt != 2'd2);
  assign push    = buf_rdy && sel_vld && bus.s_axis_tvalid[sel];
  assign pop     = (cnt != 2'd0) && bus.m_axis_tready;

  always_comb begin
    ready = '0;
    if (buf_rdy && sel_vld) ready[sel] = 1'b1;
  end
  assign bus.s_axis_tready = ready;

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (ID_WIDTH'(i) == sel) begin
        in_beat.dat  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_beat.keep = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        in_beat.user = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        in_beat.last = bus.s_axis_tlast[i];
      end
    end
    in_beat.tid = sel;
  end

  // A single-beat frame is accepted in IDLE and leaves the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      grant <= '0;
    end else if (push) begin
      grant <= sel;
      if (in_beat.last) begin
        state <= ST_IDLE;
        ptr   <= next_id(sel);
      end else begin
        state <= ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_beat;
          else             tail <= in_beat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= tail;
          cnt <= cnt - 2'd1;
        end
        // Push with pop only happens at one entry, so the new beat goes straight to the head.
        2'b11:   head <= in_beat;
        default: ;
      endcase
    end
  end

  assign bus.m_axis_tvalid = (cnt != 2'd0);
  assign bus.m_axis_tdata  = head.dat;
  assign bus.m_axis_tkeep  = head.keep;
  assign bus.m_axis_tlast  = head.last;
  assign bus.m_axis_tuser  = head.user;
  assign bus.m_axis_tid    = head.tid;
  assign bus.busy          = (state == ST_LOCKED);
  assign bus.grant_port    = grant;

endmodule

// File: tb/tb_rmt_ingress_arb.sv
// Bench for rmt_ingress_arb: table scenarios, hand-written corner sequences and randomized
// traffic, all checked against a frame-level round-robin model.
module tb_rmt_ingress_arb;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 1;
  localparam int PC = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic [IW-1:0] tid;
    int            cyc;
  } bt_t;

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][3:0] len;
    logic [3:0]      nrep;
    logic [1:0]      rdy;
    logic [3:0][3:0] ord;
    logic [2:0]      nper;
    logic [7:0]      nbeats;
    logic            contig;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rmt_ingress_arb_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                       .PORT_COUNT(PC), .ID_WIDTH(IW)) bus ();

  rmt_ingress_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                    .PORT_COUNT(PC), .ID_WIDTH(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  bt_t src_q[PC][$];
  bt_t mdl_q[PC][$];
  bt_t exp_q[$];
  bt_t got_q[$];
  logic [PC-1:0] hold = '0;
  logic [PC-1:0] mid = '0;
  logic [PC-1:0] fire_s = '0;
  logic saw_busy = 1'b0;
  int fired[PC];
  int gap_pct = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int nfr = 0;
  int total = 0;
  int bad = 0;
  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < PC; p++) begin
      logic v;
      if (src_q[p].size() == 0 || hold[p])                v = 1'b0;
      else if (bus.s_axis_tvalid[p] && !fire_s[p])        v = 1'b1;
      else if (mid[p] && $urandom_range(99) < gap_pct)    v = 1'b0;
      else                                                v = 1'b1;
      bus.s_axis_tvalid[p] = v;
      if (src_q[p].size() > 0) begin
        bus.s_axis_tdata[p*DW +: DW] = src_q[p][0].dat;
        bus.s_axis_tkeep[p*KW +: KW] = src_q[p][0].keep;
        bus.s_axis_tuser[p*UW +: UW] = src_q[p][0].user;
        bus.s_axis_tlast[p]          = src_q[p][0].last;
      end
    end
    case (rdy_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus.m_axis_tready = 1'($urandom_range(1));
    endcase
  endtask

  // Sources, sink and output-hold monitor, sampled at negedge, driven just after posedge.
  initial begin : engine
    logic        stall_q;
    logic [40:0] snap;
    logic [40:0] snap_q;
    bt_t         g;
    stall_q = 1'b0;
    snap_q  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      snap = {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser,
              bus.m_axis_tlast, bus.m_axis_tid};
      if (rst_n && stall_q) chk("hold_stable", 64'(snap), 64'(snap_q));
      stall_q = rst_n && bus.m_axis_tvalid && !bus.m_axis_tready;
      snap_q  = snap;
      if (rst_n && bus.busy) saw_busy = 1'b1;
      for (int p = 0; p < PC; p++) begin
        fire_s[p] = rst_n && bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
        if (fire_s[p]) fired[p]++;
      end
      if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
        g.dat  = bus.m_axis_tdata;
        g.keep = bus.m_axis_tkeep;
        g.user = bus.m_axis_tuser;
        g.last = bus.m_axis_tlast;
        g.tid  = bus.m_axis_tid;
        g.cyc  = cyc;
        got_q.push_back(g);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < PC; p++) begin
        if (fire_s[p] && src_q[p].size() > 0) begin
          mid[p] = !src_q[p][0].last;
          void'(src_q[p].pop_front());
        end
      end
      drive();
    end
  end

  task automatic add_frame(input int p, input int len);
    for (int b = 0; b < len; b++) begin
      bt_t x;
      x.dat  = {8'(p), 8'(nfr), 8'(b), 8'($urandom)};
      x.keep = KW'($urandom);
      x.user = UW'($urandom);
      x.last = (b == len - 1);
      x.tid  = '0;
      x.cyc  = 0;
      src_q[p].push_back(x);
      mdl_q[p].push_back(x);
    end
    nfr++;
  endtask

  task automatic take_frame(input int p);
    bt_t b;
    do begin
      b = mdl_q[p].pop_front();
      b.tid = IW'(p);
      exp_q.push_back(b);
    end while (!b.last && mdl_q[p].size() > 0);
  endtask

  // Whole frames in round-robin order over ports that still have traffic and are enabled.
  task automatic model(input int start, input logic [PC-1:0] en);
    int  ptr;
    bit  any;
    ptr = start;
    while (1) begin
      any = 1'b0;
      for (int i = 0; i < PC && !any; i++) begin
        int p;
        p = (ptr + i) % PC;
        if (en[p] && mdl_q[p].size() > 0) begin
          take_frame(p);
          ptr = (p + 1) % PC;
          any = 1'b1;
        end
      end
      if (!any) break;
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < PC; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
      fired[p] = 0;
    end
    exp_q.delete();
    got_q.delete();
    hold = '0;
    mid = '0;
    saw_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_fire(input int p, input int n, input string name);
    int k;
    k = 0;
    while (fired[p] < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 64'(fired[p] >= n), 64'd1);
  endtask

  task automatic finish_run(input string name, input int budget);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (8) @(negedge clk);
    #1;
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i),
          64'({got_q[i].dat, got_q[i].keep, got_q[i].user, got_q[i].last, got_q[i].tid}),
          64'({exp_q[i].dat, exp_q[i].keep, exp_q[i].user, exp_q[i].last, exp_q[i].tid}));
  endtask

  task automatic chk_contig(input string name);
    if (got_q.size() > 0)
      chk(name, 64'(got_q[got_q.size()-1].cyc - got_q[0].cyc + 1), 64'(got_q.size()));
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   fi;
    logic exp_busy;
    v = vt[idx];
    do_reset();
    rdy_mode = int'(v.rdy);
    gap_pct = 0;
    bus.port_en = v.en;
    exp_busy = 1'b0;
    for (int r = 0; r < int'(v.nrep); r++)
      for (int p = 0; p < PC; p++)
        if (v.len[p] != 0) add_frame(p, int'(v.len[p]));
    for (int p = 0; p < PC; p++)
      if (v.en[p] && v.len[p] > 1) exp_busy = 1'b1;
    model(0, v.en);
    finish_run($sformatf("vec%0d", idx), 1000);
    chk($sformatf("vec%0d_nbeats", idx), 64'(got_q.size()), 64'(v.nbeats));
    fi = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i].last) begin
        chk($sformatf("vec%0d_order%0d", idx, fi), 64'(got_q[i].tid),
            64'(v.ord[2'(fi % int'(v.nper))]));
        fi++;
      end
    end
    if (v.contig) chk_contig($sformatf("vec%0d_contig", idx));
    chk($sformatf("vec%0d_busy_seen", idx), 64'(saw_busy), 64'(exp_busy));
  endtask

  initial begin : watchdog
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.port_en = '1;
    for (int p = 0; p < PC; p++) fired[p] = 0;
    vt[0] = '{en: 4'hF, len: 16'h3333, nrep: 4'd1, rdy: 2'd0, ord: 16'h3210, nper: 3'd4, nbeats: 8'd12, contig: 1'b1};
    vt[1] = '{en: 4'hB, len: 16'h2222, nrep: 4'd2, rdy: 2'd0, ord: 16'h0310, nper: 3'd3, nbeats: 8'd12, contig: 1'b1};
    vt[2] = '{en: 4'hF, len: 16'h1111, nrep: 4'd8, rdy: 2'd0, ord: 16'h3210, nper: 3'd4, nbeats: 8'd32, contig: 1'b1};
    vt[3] = '{en: 4'h0, len: 16'h2222, nrep: 4'd1, rdy: 2'd0, ord: 16'h0000, nper: 3'd1, nbeats: 8'd0,  contig: 1'b0};
    vt[4] = '{en: 4'hA, len: 16'h2141, nrep: 4'd3, rdy: 2'd1, ord: 16'h0031, nper: 3'd2, nbeats: 8'd18, contig: 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(bus.m_axis_tdata), 64'd0);
    chk("rst_m_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
    chk("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
    chk("rst_m_tuser", 64'(bus.m_axis_tuser), 64'd0);
    chk("rst_m_tid", 64'(bus.m_axis_tid), 64'd0);
    chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_grant_port", 64'(bus.grant_port), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Port 0 shows up while port 2 holds the grant: it must wait for port 2's tlast.
    do_reset();
    rdy_mode = 0;
    bus.port_en = 4'hF;
    hold = 4'b0001;
    add_frame(2, 4);
    add_frame(0, 3);
    wait_fire(2, 1, "h1_first_beat");
    hold = '0;
    for (int k = 0; k < 50 && fired[2] < 4; k++) begin
      @(negedge clk);
      #1;
      if (fired[2] < 4) begin
        chk("h1_p0_blocked", 64'(bus.s_axis_tready[0]), 64'd0);
        chk("h1_busy", 64'(bus.busy), 64'd1);
        chk("h1_grant_port", 64'(bus.grant_port), 64'd2);
      end
    end
    model(2, 4'hF);
    finish_run("h1", 200);
    chk_contig("h1_contig");

    // Disabling port 0 mid-frame lets that frame finish but blocks its next one.
    do_reset();
    rdy_mode = 0;
    bus.port_en = 4'b1011;
    add_frame(0, 4);
    add_frame(0, 2);
    add_frame(1, 2);
    add_frame(3, 2);
    wait_fire(0, 2, "h2_mid_frame");
    bus.port_en = 4'b1010;
    take_frame(0);
    model(1, 4'b1010);
    finish_run("h2", 200);
    chk("h2_p0_left", 64'(src_q[0].size()), 64'd2);
    chk("h2_p0_rdy", 64'(bus.s_axis_tready[0]), 64'd0);

    // Reset in the middle of a 5-beat frame.
    do_reset();
    rdy_mode = 0;
    bus.port_en = 4'hF;
    add_frame(0, 5);
    wait_fire(0, 2, "h4_mid_frame");
    #2;
    rst_n = 1'b0;
    #1;
    chk("h4_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("h4_rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("h4_rst_busy", 64'(bus.busy), 64'd0);
    chk("h4_rst_m_tdata", 64'(bus.m_axis_tdata), 64'd0);
    @(posedge clk);
    #2;
    clear_all();
    add_frame(1, 2);
    add_frame(0, 2);
    @(posedge clk);
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("h4_tready_after_release", 64'(bus.s_axis_tready), 64'd0);
    @(posedge clk);
    #2;
    chk("h4_first_winner", 64'(bus.s_axis_tready), 64'b0001);
    model(0, 4'hF);
    finish_run("h4", 200);

    for (int r = 0; r < 4; r++) begin
      logic [PC-1:0] en;
      do_reset();
      en = PC'($urandom_range(1, 15));
      bus.port_en = en;
      rdy_mode = 2;
      gap_pct = 25;
      for (int p = 0; p < PC; p++) begin
        int nf;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 5));
      end
      model(0, en);
      finish_run($sformatf("rnd%0d", r), 3000);
    end
    gap_pct = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
